ip_codma_dp_ctrl: RTL and testbench

Data-phase controller for the CODMA memory port; it consumes the address-phase FIFO. It issues the FIFO pop, latches the head entry (read, write, addr, size) and drives the data beats of that transaction against the memory handshake. Read data is returned to the DMA core and write data is forwarded from it. The block sits between the address-phase FIFO output and the memory data bus.

---
 rtl/ip_codma_fifo_pkg.sv | 24 ++
 rtl/ip_codma_machine_states_pkg.sv | 14 +
 rtl/ip_codma_dp_beat_cnt.sv | 26 ++
 rtl/ip_codma_dp_ctrl.sv | 127 ++++++++++++
 tb/tb_ip_codma_dp_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ip_codma_fifo_pkg.sv
// ip_codma_fifo_pkg: address-phase FIFO entry shared by the FIFO and the data-phase controller.
// Revision: 1.0
`default_nettype none

package ip_codma_fifo_pkg;

    localparam int NO_OF_AF_BUFFERS = 4;
    localparam int AP_ADDR_W        = 32;

    typedef struct packed {
        logic                 read;
        logic                 write;
        logic [AP_ADDR_W-1:0] addr;
        logic [3:0]           size;
    } ap_entry_t;

    // Exactly one of read/write must be set for an entry to be executable.
    function automatic logic entry_is_legal(input logic read, input logic write);
        return read ^ write;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ip_codma_machine_states_pkg.sv
// ip_codma_machine_states_pkg: state encodings for the CODMA controllers.
// Revision: 1.0
`default_nettype none

package ip_codma_machine_states_pkg;

    typedef enum logic [0:0] {
        DP_IDLE = 1'b0,
        DP_DATA = 1'b1
    } dp_state_t;

endpackage

`default_nettype wire

// File: rtl/ip_codma_dp_beat_cnt.sv
// ip_codma_dp_beat_cnt: saturating 16-bit counter of completed data beats.
// Revision: 1.0
`default_nettype none

module ip_codma_dp_beat_cnt (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] r_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= 16'h0000;
        end else if (inc_i && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/ip_codma_dp_ctrl.sv
// ip_codma_dp_ctrl: CODMA data-phase controller; pops the address-phase FIFO and runs the data beats.
// Optional macro CODMA_DP_BEAT_CNT_EN adds beat_cnt_o. Revision: 1.0
`default_nettype none

module ip_codma_dp_ctrl
    import ip_codma_fifo_pkg::*;
    import ip_codma_machine_states_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [2:0]        ap_fifo_count_i,
    input  logic              ap_read_i,
    input  logic              ap_write_i,
    input  logic [ADDR_W-1:0] ap_addr_i,
    input  logic [3:0]        ap_size_i,
    output logic              fifo_rd_next_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
`ifdef CODMA_DP_BEAT_CNT_EN
    output logic [15:0]       beat_cnt_o,
`endif
    output logic              busy_o,
    output logic              err_o
);

    localparam int BYTES_PER_BEAT = DATA_W / 8;

    dp_state_t         r_state;
    dp_state_t         w_state_nxt;
    logic              w_take;
    logic              w_legal;
    logic              w_beat_done;
    logic              w_last_beat;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_beats_left;
    logic              r_err;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    // Pop is gated by reset so a non-empty FIFO is never popped while reset is held.
    assign w_take      = (r_state == DP_IDLE) && (ap_fifo_count_i != 3'd0) && !reset_i;
    assign w_legal     = entry_is_legal(ap_read_i, ap_write_i);
    assign w_beat_done = (r_state == DP_DATA) && mem_ready_i;
    assign w_last_beat = w_beat_done && (r_beats_left == 4'd0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= DP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DP_IDLE: if (w_take && w_legal) w_state_nxt = DP_DATA;
            DP_DATA: if (w_last_beat)       w_state_nxt = DP_IDLE;
            default:                        w_state_nxt = DP_IDLE;
        endcase
    end

    // The running address register equals base + beat_idx * bytes-per-beat; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= 4'd0;
            r_err        <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_rd_valid <= w_beat_done && !r_we;
            if (w_take && w_legal) begin
                r_we         <= ap_write_i;
                r_addr       <= ap_addr_i;
                r_beats_left <= ap_size_i;
            end else if (w_beat_done) begin
                r_addr       <= r_addr + ADDR_W'(BYTES_PER_BEAT);
                r_beats_left <= r_beats_left - 4'd1;
            end
            if (w_take && !w_legal) begin
                r_err <= 1'b1;
            end
            if (w_beat_done && !r_we) begin
                r_rd_data <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        fifo_rd_next_o = w_take;
        busy_o         = (r_state == DP_DATA);
        mem_req_o      = (r_state == DP_DATA);
        mem_we_o       = (r_state == DP_DATA) && r_we;
        mem_addr_o     = (r_state == DP_DATA) ? r_addr : '0;
        mem_wdata_o    = ((r_state == DP_DATA) && r_we) ? wr_data_i : '0;
        wr_ack_o       = (r_state == DP_DATA) && r_we && mem_ready_i;
        rd_data_o      = r_rd_data;
        rd_valid_o     = r_rd_valid;
        err_o          = r_err;
    end

`ifdef CODMA_DP_BEAT_CNT_EN
    ip_codma_dp_beat_cnt u_beat_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (w_beat_done),
        .count_o (beat_cnt_o)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ip_codma_dp_ctrl.sv
// tb_ip_codma_dp_ctrl: directed self-checking bench for ip_codma_dp_ctrl.
// Revision: 1.0
`default_nettype none

module tb_ip_codma_dp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  count = 3'd0;
    logic        ap_read = 1'b0;
    logic        ap_write = 1'b0;
    logic [31:0] ap_addr = 32'h0;
    logic [3:0]  ap_size = 4'd0;
    logic        pop, req, we, rd_valid, wr_ack, busy, err;
    logic [31:0] mem_addr, mem_wdata, rd_data;
    logic        ready = 1'b1;
    logic [31:0] rdata = 32'h0;
    logic [31:0] wr_data = 32'h0;
`ifdef CODMA_DP_BEAT_CNT_EN
    logic [15:0] beat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ip_codma_dp_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .reset_i(rst), .ap_fifo_count_i(count),
        .ap_read_i(ap_read), .ap_write_i(ap_write), .ap_addr_i(ap_addr), .ap_size_i(ap_size),
        .fifo_rd_next_o(pop), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ready_i(ready), .mem_rdata_i(rdata),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
`ifdef CODMA_DP_BEAT_CNT_EN
        .beat_cnt_o(beat_cnt),
`endif
        .busy_o(busy), .err_o(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if ({pop, req, we, rd_valid, wr_ack, busy, err} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000000", {pop, req, we, rd_valid, wr_ack, busy, err}); end
        n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00000000", rd_data); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=00000000", mem_addr); end
`ifdef CODMA_DP_BEAT_CNT_EN
        n_tests++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_beat_cnt got=%h exp=0000", beat_cnt); end
`endif
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++; if ({pop, req, busy} !== 3'b000) begin n_fail++; $display("FAIL idle_quiet cyc=%0d got=%b exp=000", i, {pop, req, busy}); end
            step();
        end
    endtask

    task automatic test_read_burst();
        count = 3'd1; ap_read = 1'b1; ap_write = 1'b0; ap_addr = 32'h1000; ap_size = 4'd3; ready = 1'b1;
        #1;
        n_tests++; if ({pop, busy, req} !== 3'b100) begin n_fail++; $display("FAIL rd_pop got=%b exp=100", {pop, busy, req}); end
        step();
        count = 3'd0; ap_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdata = 32'hA000_0000 + i;
            #1;
            n_tests++; if ({req, we, pop} !== 3'b100) begin n_fail++; $display("FAIL rd_beat_ctrl beat=%0d got=%b exp=100", i, {req, we, pop}); end
            n_tests++; if (mem_addr !== 32'h1000 + 4 * i) begin n_fail++; $display("FAIL rd_beat_addr beat=%0d got=%h exp=%h", i, mem_addr, 32'h1000 + 4 * i); end
            n_tests++; if (rd_valid !== (i > 0)) begin n_fail++; $display("FAIL rd_valid beat=%0d got=%b exp=%b", i, rd_valid, (i > 0)); end
            if (i > 0) begin
                n_tests++; if (rd_data !== 32'hA000_0000 + i - 1) begin n_fail++; $display("FAIL rd_data beat=%0d got=%h exp=%h", i, rd_data, 32'hA000_0000 + i - 1); end
            end
            step();
        end
        #1;
        n_tests++; if ({busy, req, rd_valid} !== 3'b001) begin n_fail++; $display("FAIL rd_end got=%b exp=001", {busy, req, rd_valid}); end
        n_tests++; if (rd_data !== 32'hA000_0003) begin n_fail++; $display("FAIL rd_last_data got=%h exp=a0000003", rd_data); end
        step();
        #1;
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse got=%b exp=0", rd_valid); end
        step();
    endtask

    task automatic test_write_stall();
        int acks = 0;
        count = 3'd1; ap_read = 1'b0; ap_write = 1'b1; ap_addr = 32'h2000; ap_size = 4'd1; ready = 1'b0;
        #1;
        n_tests++; if (pop !== 1'b1) begin n_fail++; $display("FAIL wr_pop got=%b exp=1", pop); end
        step();
        count = 3'd0; ap_write = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 3; s++) begin
                ready = (s == 2);
                wr_data = 32'hDEAD_0000 + b;
                #1;
                if (wr_ack) acks++;
                n_tests++; if ({req, we, pop} !== 3'b110) begin n_fail++; $display("FAIL wr_ctrl beat=%0d s=%0d got=%b exp=110", b, s, {req, we, pop}); end
                n_tests++; if (mem_addr !== 32'h2000 + 4 * b) begin n_fail++; $display("FAIL wr_addr beat=%0d s=%0d got=%h exp=%h", b, s, mem_addr, 32'h2000 + 4 * b); end
                n_tests++; if (wr_ack !== (s == 2)) begin n_fail++; $display("FAIL wr_ack beat=%0d s=%0d got=%b exp=%b", b, s, wr_ack, (s == 2)); end
                if (s == 2) begin
                    n_tests++; if (mem_wdata !== 32'hDEAD_0000 + b) begin n_fail++; $display("FAIL wr_wdata beat=%0d got=%h exp=%h", b, mem_wdata, 32'hDEAD_0000 + b); end
                end
                step();
            end
        end
        ready = 1'b1;
        #1;
        n_tests++; if ({busy, we, wr_ack, rd_valid} !== 4'b0000) begin n_fail++; $display("FAIL wr_end got=%b exp=0000", {busy, we, wr_ack, rd_valid}); end
        n_tests++; if (acks !== 2) begin n_fail++; $display("FAIL wr_ack_count got=%0d exp=2", acks); end
        step();
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        count = 3'd2; ap_read = 1'b1; ap_write = 1'b0; ap_addr = 32'h3000; ap_size = 4'd0; ready = 1'b1;
        #1; if (pop) pops++;
        n_tests++; if ({pop, busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_pop1 got=%b exp=10", {pop, busy}); end
        step();
        count = 3'd1; ap_read = 1'b0; ap_write = 1'b1; ap_addr = 32'h4000; wr_data = 32'h5555_AAAA;
        #1; if (pop) pops++;
        n_tests++; if ({req, we, pop} !== 3'b100 || mem_addr !== 32'h3000) begin n_fail++; $display("FAIL b2b_read got=%b/%h exp=100/00003000", {req, we, pop}, mem_addr); end
        step();
        #1; if (pop) pops++;
        n_tests++; if ({pop, busy, req} !== 3'b100) begin n_fail++; $display("FAIL b2b_bubble got=%b exp=100", {pop, busy, req}); end
        step();
        count = 3'd0; ap_write = 1'b0;
        #1; if (pop) pops++;
        n_tests++; if ({req, we, wr_ack} !== 3'b111 || mem_addr !== 32'h4000) begin n_fail++; $display("FAIL b2b_write got=%b/%h exp=111/00004000", {req, we, wr_ack}, mem_addr); end
        step();
        #1; if (pop) pops++;
        n_tests++; if ({busy, pop} !== 2'b00) begin n_fail++; $display("FAIL b2b_end got=%b exp=00", {busy, pop}); end
        n_tests++; if (pops !== 2) begin n_fail++; $display("FAIL b2b_pop_count got=%0d exp=2", pops); end
        step();
    endtask

    task automatic test_illegal();
        count = 3'd1; ap_read = 1'b1; ap_write = 1'b1; ap_addr = 32'h9000; ap_size = 4'd2;
        #1;
        n_tests++; if ({pop, err} !== 2'b10) begin n_fail++; $display("FAIL ill_pop got=%b exp=10", {pop, err}); end
        step();
        count = 3'd0; ap_read = 1'b0; ap_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if ({err, busy, req} !== 3'b100) begin n_fail++; $display("FAIL ill_hold cyc=%0d got=%b exp=100", i, {err, busy, req}); end
            step();
        end
        count = 3'd1; ap_read = 1'b1; ap_addr = 32'hFFFF_FFFC; ap_size = 4'd1;
        #1;
        n_tests++; if (pop !== 1'b1) begin n_fail++; $display("FAIL ill_next_pop got=%b exp=1", pop); end
        step();
        count = 3'd0; ap_read = 1'b0;
        #1;
        n_tests++; if (req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL ill_next_beat0 got=%b/%h exp=1/fffffffc", req, mem_addr); end
        step();
        #1;
        n_tests++; if (req !== 1'b1 || mem_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL addr_wrap got=%b/%h exp=1/00000000", req, mem_addr); end
        step();
        #1;
        n_tests++; if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL ill_err_sticky got=%b exp=01", {busy, err}); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        count = 3'd1; ap_read = 1'b1; ap_addr = 32'h5000; ap_size = 4'd3; ready = 1'b1;
        #1;
        step();
        ap_read = 1'b0;
        step();
        step();
        #1;
        n_tests++; if (req !== 1'b1 || mem_addr !== 32'h5008) begin n_fail++; $display("FAIL mid_beat2 got=%b/%h exp=1/00005008", req, mem_addr); end
        rst = 1'b1;
        #1;
        n_tests++; if ({pop, req, we, rd_valid, wr_ack, busy, err} !== 7'b0) begin n_fail++; $display("FAIL mid_reset_outs got=%b exp=0000000", {pop, req, we, rd_valid, wr_ack, busy, err}); end
        n_tests++; if (mem_addr !== 32'h0 || rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data got=%h/%h exp=0/0", mem_addr, rd_data); end
`ifdef CODMA_DP_BEAT_CNT_EN
        n_tests++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_reset_beat_cnt got=%h exp=0000", beat_cnt); end
`endif
        step();
        count = 3'd0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if ({pop, req, busy} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=000", i, {pop, req, busy}); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_stall();
        test_back_to_back();
        test_illegal();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
